// File: rtl/mem_arbiter.sv
// Arbitrates icache refill reads and dcache reads/writes onto one burst memory port.
// Define ROUND_ROBIN_EN to alternate priority after each transaction; default is fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_rw,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_rw,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              busy,
    output logic              err
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the arbiter only forwards ready/valid combinationally and never stores a beat.
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner_dc;
    logic             r_lock;
    logic             r_lock_dc;
    logic             r_err;
    logic [1:0]       r_boot;
    logic [CNT_W-1:0] r_beat;

    logic w_pick_dc;
    logic w_grant_ok;
    logic w_req_hs;
    logic w_rd_beat;
    logic w_wr_beat;
    logic w_last;

`ifdef ROUND_ROBIN_EN
    logic r_rr_ic;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ic <= 1'b0;
        end else if ((w_rd_beat || w_wr_beat) && w_last) begin
            r_rr_ic <= ~r_rr_ic;
        end
    end
`endif

    // A stalled request keeps its owner until the memory accepts it.
    always_comb begin
        w_pick_dc = dc_req_valid;
        if (r_lock) w_pick_dc = r_lock_dc;
`ifdef ROUND_ROBIN_EN
        else if (dc_req_valid && ic_req_valid) w_pick_dc = ~r_rr_ic;
`endif
    end

    // Grants are held off through the first full cycle after reset release.
    assign w_grant_ok = (r_state == IDLE) && r_boot[1];
    assign w_req_hs   = mem_req_valid && mem_req_ready;
    assign w_rd_beat  = (r_state == RD) && mem_resp_valid;
    assign w_wr_beat  = (r_state == WR) && dc_wdata_valid && mem_wdata_ready;
    assign w_last     = (r_beat == LAST_BEAT);

    assign mem_req_valid = w_grant_ok && (w_pick_dc ? dc_req_valid : ic_req_valid);
    assign mem_req_addr  = w_pick_dc ? dc_req_addr : ic_req_addr;
    assign mem_req_rw    = w_pick_dc && dc_req_rw;
    assign dc_req_ready  = w_grant_ok && w_pick_dc && mem_req_ready;
    assign ic_req_ready  = w_grant_ok && !w_pick_dc && mem_req_ready;

    assign ic_resp_valid = w_rd_beat && !r_owner_dc;
    assign dc_resp_valid = w_rd_beat && r_owner_dc;
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;

    assign mem_wdata_valid = (r_state == WR) && dc_wdata_valid;
    assign dc_wdata_ready  = (r_state == WR) && mem_wdata_ready;
    assign mem_wdata       = dc_wdata;

    assign busy = (r_state != IDLE);
    assign err  = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_hs) w_state_nxt = mem_req_rw ? WR : RD;
            RD:      if (w_rd_beat && w_last) w_state_nxt = IDLE;
            WR:      if (w_wr_beat && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_owner_dc <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_dc  <= 1'b0;
            r_err      <= 1'b0;
            r_boot     <= 2'b00;
            r_beat     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_boot    <= {r_boot[0], 1'b1};
            r_lock    <= mem_req_valid && !mem_req_ready;
            r_lock_dc <= w_pick_dc;
            if (w_req_hs) begin
                r_owner_dc <= w_pick_dc;
                r_beat     <= '0;
            end else if (w_rd_beat || w_wr_beat) begin
                r_beat <= r_beat + 1'b1;
            end
            // Read beats arriving with no read burst in flight are dropped and flagged.
            if (mem_resp_valid && (r_state != RD)) r_err <= 1'b1;
        end
    end

endmodule
